// File: rtl/ext_reg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ext_reg_fifo
// Brief    : TX/RX FIFO backing stage behind an external register slice.
//            Optional macro EXT_REG_FIFO_EMPTY_MARK_EN: empty heads read all-ones.
// Revision : 1.0
// ============================================================================
module ext_reg_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       reg_qe_i,
    input  logic [DW-1:0]              reg_q_i,
    input  logic                       reg_qre_i,
    output logic [DW-1:0]              reg_d_o,
    output logic                       tx_valid_o,
    output logic [DW-1:0]              tx_data_o,
    input  logic                       tx_ready_i,
    input  logic                       rx_valid_i,
    input  logic [DW-1:0]              rx_data_i,
    output logic                       rx_ready_o,
    output logic [$clog2(DEPTH+1)-1:0] tx_depth_o,
    output logic [$clog2(DEPTH+1)-1:0] rx_depth_o,
    output logic                       tx_overflow_o,
    output logic                       rx_underflow_o
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(DEPTH - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
`ifdef EXT_REG_FIFO_EMPTY_MARK_EN
    localparam logic [DW-1:0] c_EMPTY = {DW{1'b1}};
`else
    localparam logic [DW-1:0] c_EMPTY = {DW{1'b0}};
`endif

    function automatic logic [c_AW-1:0] f_inc(input logic [c_AW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_AW'(1);
    endfunction

    logic [DW-1:0]   r_tx_mem [DEPTH];
    logic [DW-1:0]   r_rx_mem [DEPTH];
    logic [c_AW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [c_CW-1:0] r_tx_cnt, r_rx_cnt;
    logic            r_tx_ovf, r_rx_unf;

    logic w_tx_pop, w_tx_push, w_rx_pop, w_rx_push;
    logic w_tx_empty, w_rx_empty;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_rx_empty = (r_rx_cnt == '0);

    // A full TX FIFO still takes a write when the head leaves in the same cycle.
    assign w_tx_pop  = !clr_i && !w_tx_empty && tx_ready_i;
    assign w_tx_push = !clr_i && reg_qe_i && ((r_tx_cnt != c_FULL) || w_tx_pop);
    assign w_rx_push = !clr_i && rx_valid_i && rx_ready_o;
    assign w_rx_pop  = !clr_i && reg_qre_i && !w_rx_empty;

    assign tx_valid_o     = !w_tx_empty;
    assign tx_data_o      = w_tx_empty ? c_EMPTY : r_tx_mem[r_tx_rd];
    assign rx_ready_o     = (r_rx_cnt != c_FULL);
    assign reg_d_o        = w_rx_empty ? c_EMPTY : r_rx_mem[r_rx_rd];
    assign tx_depth_o     = r_tx_cnt;
    assign rx_depth_o     = r_rx_cnt;
    assign tx_overflow_o  = r_tx_ovf;
    assign rx_underflow_o = r_rx_unf;

    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= reg_q_i;
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
            r_tx_ovf <= 1'b0;
        end else if (clr_i) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_cnt <= '0;
            r_tx_ovf <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wr <= f_inc(r_tx_wr);
            if (w_tx_pop)  r_tx_rd <= f_inc(r_tx_rd);
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + c_CW'(1);
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - c_CW'(1);
            if (reg_qe_i && !w_tx_push) r_tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            r_rx_unf <= 1'b0;
        end else if (clr_i) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_cnt <= '0;
            r_rx_unf <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wr <= f_inc(r_rx_wr);
            if (w_rx_pop)  r_rx_rd <= f_inc(r_rx_rd);
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + c_CW'(1);
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - c_CW'(1);
            // Read on an empty FIFO: no pop and no fall-through from a same-cycle push.
            if (reg_qre_i && w_rx_empty) r_rx_unf <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_reg_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_reg_fifo
// Brief    : Self-checking bench driving a Depth=4 and a Depth=3 instance in
//            lockstep against an array-based FIFO reference model.
// Revision : 1.0
// ============================================================================
module tb_ext_reg_fifo;

`ifdef EXT_REG_FIFO_EMPTY_MARK_EN
    localparam logic [31:0] c_EMPTY = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] c_EMPTY = 32'h0000_0000;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic        qe = 1'b0, qre = 1'b0, tready = 1'b0, rvalid = 1'b0;
    logic [31:0] q = '0, rdata = '0;

    logic [31:0] regd4, txd4, regd3, txd3;
    logic        txv4, rxr4, ovf4, unf4, txv3, rxr3, ovf3, unf3;
    logic [2:0]  txdep4, rxdep4;
    logic [1:0]  txdep3, rxdep3;

    always #5 clk = ~clk;

    ext_reg_fifo #(.DW(32), .DEPTH(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .reg_qe_i(qe), .reg_q_i(q), .reg_qre_i(qre), .reg_d_o(regd4),
        .tx_valid_o(txv4), .tx_data_o(txd4), .tx_ready_i(tready),
        .rx_valid_i(rvalid), .rx_data_i(rdata), .rx_ready_o(rxr4),
        .tx_depth_o(txdep4), .rx_depth_o(rxdep4),
        .tx_overflow_o(ovf4), .rx_underflow_o(unf4)
    );

    ext_reg_fifo #(.DW(32), .DEPTH(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .reg_qe_i(qe), .reg_q_i(q), .reg_qre_i(qre), .reg_d_o(regd3),
        .tx_valid_o(txv3), .tx_data_o(txd3), .tx_ready_i(tready),
        .rx_valid_i(rvalid), .rx_data_i(rdata), .rx_ready_o(rxr3),
        .tx_depth_o(txdep3), .rx_depth_o(rxdep3),
        .tx_overflow_o(ovf3), .rx_underflow_o(unf3)
    );

    int          n_cmp = 0, n_fail = 0;
    int          dep [2] = '{4, 3};
    logic [31:0] mtx [2][8];
    logic [31:0] mrx [2][8];
    int          ntx [2], nrx [2];
    bit          movf [2], munf [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[depth%0d] observed=%h expected=%h", tag, dep[k], obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ntx[k] = 0; nrx[k] = 0; movf[k] = 0; munf[k] = 0;
        end
    endtask

    task automatic check_all();
        logic [31:0] o_regd, o_txd, o_td, o_rd;
        logic        o_txv, o_rxr, o_ov, o_un;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                o_regd = regd4; o_txd = txd4; o_txv = txv4; o_rxr = rxr4;
                o_ov = ovf4; o_un = unf4; o_td = 32'(txdep4); o_rd = 32'(rxdep4);
            end else begin
                o_regd = regd3; o_txd = txd3; o_txv = txv3; o_rxr = rxr3;
                o_ov = ovf3; o_un = unf3; o_td = 32'(txdep3); o_rd = 32'(rxdep3);
            end
            chk("tx_valid", k, 32'(o_txv), 32'(ntx[k] != 0));
            chk("tx_data", k, o_txd, (ntx[k] != 0) ? mtx[k][0] : c_EMPTY);
            chk("rx_ready", k, 32'(o_rxr), 32'(nrx[k] < dep[k]));
            chk("reg_d", k, o_regd, (nrx[k] != 0) ? mrx[k][0] : c_EMPTY);
            chk("tx_depth", k, o_td, 32'(ntx[k]));
            chk("rx_depth", k, o_rd, 32'(nrx[k]));
            chk("tx_overflow", k, 32'(o_ov), 32'(movf[k]));
            chk("rx_underflow", k, 32'(o_un), 32'(munf[k]));
        end
    endtask

    // Applies the FIFO rules to the current inputs, as the coming edge will.
    task automatic model_step();
        bit tpop, tpush, rpop, rpush;
        if (!rst_n || clr) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            tpop  = (ntx[k] > 0) && tready;
            tpush = qe && ((ntx[k] < dep[k]) || tpop);
            if (qe && !tpush) movf[k] = 1;
            rpush = rvalid && (nrx[k] < dep[k]);
            rpop  = qre && (nrx[k] > 0);
            if (qre && nrx[k] == 0) munf[k] = 1;
            if (tpop) begin
                for (int i = 0; i < 7; i++) mtx[k][i] = mtx[k][i+1];
                ntx[k]--;
            end
            if (tpush) begin mtx[k][ntx[k]] = q; ntx[k]++; end
            if (rpop) begin
                for (int i = 0; i < 7; i++) mrx[k][i] = mrx[k][i+1];
                nrx[k]--;
            end
            if (rpush) begin mrx[k][nrx[k]] = rdata; nrx[k]++; end
        end
    endtask

    task automatic op(input logic c, input logic w, input logic [31:0] wd, input logic r,
                      input logic tr, input logic rv, input logic [31:0] rd);
        clr = c; qe = w; q = wd; qre = r; tready = tr; rvalid = rv; rdata = rd;
        #1;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Fill TX, overflow, then drain in order
        op(0, 1, 32'h11, 0, 0, 0, 0);
        op(0, 1, 32'h22, 0, 0, 0, 0);
        op(0, 1, 32'h33, 0, 0, 0, 0);
        op(0, 1, 32'h44, 0, 0, 0, 0);
        op(0, 1, 32'h55, 0, 0, 0, 0);
        repeat (5) op(0, 0, 0, 0, 1, 0, 0);

        // Write into a full TX FIFO while the head is taken
        op(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) op(0, 1, 32'hA0 + 32'(i), 0, 0, 0, 0);
        op(0, 1, 32'h99, 0, 1, 0, 0);
        repeat (5) op(0, 0, 0, 0, 1, 0, 0);

        // RX push, read two cycles later, then read while empty
        op(0, 0, 0, 0, 0, 1, 32'hA5A5_A5A5);
        idle(2);
        op(0, 0, 0, 1, 0, 0, 0);
        idle(1);
        op(0, 0, 0, 1, 0, 0, 0);
        idle(1);

        // Back-to-back push/pop pairs wrapping the pointers
        op(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) op(0, 1, 32'(i), (i > 1), 1, 1, 32'(i));
        op(0, 0, 0, 1, 1, 0, 0);
        idle(1);

        // Fill to full on both sides then keep pushing
        for (int i = 0; i < 5; i++) op(0, 1, 32'h200 + 32'(i), 0, 0, 1, 32'h300 + 32'(i));
        for (int i = 0; i < 5; i++) op(0, 0, 0, 1, 1, 0, 0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++)
            op(($urandom_range(0, 39) == 0), 1'($urandom), $urandom, 1'($urandom),
               1'($urandom), 1'($urandom), $urandom);

        // Flush with coincident strobes
        op(1, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) op(0, 1, 32'h400 + 32'(i), 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 0, 0);
        op(0, 0, 0, 0, 1, 1, 32'h500);
        op(0, 0, 0, 0, 0, 1, 32'h501);
        op(1, 1, 32'h777, 1, 1, 1, 32'h888);
        idle(2);

        // Asynchronous reset between edges
        op(0, 1, 32'h600, 0, 0, 1, 32'h601);
        op(0, 1, 32'h602, 0, 0, 1, 32'h603);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        op(0, 1, 32'h700, 0, 0, 1, 32'h701);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
